// File: rtl/fft_stage_ctrl_pkg.sv
// Shared definitions for the FFT stage sequencer:
// state encodings and default frame geometry.
package fft_stage_ctrl_pkg;

    localparam int FFT_N_POINTS = 16;
    localparam int FFT_ADDR_W   = 4;
    localparam int FFT_STAGE_W  = 2;
    localparam int FFT_N_STAGES = 4;
    localparam int FFT_CALC_LAT = 2;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FILL       = 3'd1,
        S_CALC_PULSE = 3'd2,
        S_CALC_WAIT  = 3'd3,
        S_READ       = 3'd4,
        S_DONE       = 3'd5
    } state_t;

endpackage

// File: rtl/fft_addr_counter.sv
// Sample address counter shared by the FILL and READ sweeps.
// Wraps to zero after TC_VAL and flags the terminal count.
module fft_addr_counter
    import fft_stage_ctrl_pkg::*;
#(
    parameter int ADDR_W = FFT_ADDR_W,
    parameter int TC_VAL = FFT_N_POINTS - 1
) (
    input  logic              clk,
    input  logic              i_clr,
    input  logic              i_en,
    output logic [ADDR_W-1:0] o_count,
    output logic              o_tc
);

    logic [ADDR_W-1:0] r_count;

    assign o_tc    = (r_count == ADDR_W'(TC_VAL));
    assign o_count = r_count;

    // count while enabled, wrap at terminal count, clear wins
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_tc ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/fft_stage_ctrl.sv
// Frame sequencer for one fft_reg_stage: fill, per-stage calc, read-out.
// Optional abort input enabled by defining FFT_CTRL_ABORT_EN.
module fft_stage_ctrl
    import fft_stage_ctrl_pkg::*;
#(
    parameter int N_POINTS = FFT_N_POINTS,
    parameter int ADDR_W   = FFT_ADDR_W,
    parameter int STAGE_W  = FFT_STAGE_W,
    parameter int N_STAGES = FFT_N_STAGES,
    parameter int CALC_LAT = FFT_CALC_LAT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
`ifdef FFT_CTRL_ABORT_EN
    input  logic               abort,
`endif
    output logic               busy,
    output logic               done,
    output logic               fill_regs,
    output logic               start_calc,
    output logic               we_regs,
    output logic [ADDR_W-1:0]  addr_counter,
    output logic [STAGE_W-1:0] stage,
    output logic               sel_in,
    output logic               out_valid
);

    localparam int WAIT_W = (CALC_LAT > 0) ? $clog2(CALC_LAT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        (CALC_LAT > 0) ? WAIT_W'(CALC_LAT - 1) : '0;
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(N_STAGES - 1);

    state_t             r_state;
    state_t             w_next;
    logic [STAGE_W-1:0] r_stage;
    logic [WAIT_W-1:0]  r_wait;
    logic               w_stage_step;
    logic               w_abort;
    logic               w_addr_en;
    logic               w_addr_tc;
    logic [ADDR_W-1:0]  w_addr;

`ifdef FFT_CTRL_ABORT_EN
    assign w_abort = abort && (r_state != S_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    assign w_addr_en = (r_state == S_FILL) || (r_state == S_READ);

    fft_addr_counter #(
        .ADDR_W (ADDR_W),
        .TC_VAL (N_POINTS - 1)
    ) u_addr (
        .clk     (clk),
        .i_clr   (reset || w_abort),
        .i_en    (w_addr_en),
        .o_count (w_addr),
        .o_tc    (w_addr_tc)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // calc wait counter runs only inside CALC_WAIT
    always_ff @(posedge clk) begin
        if (reset || r_state != S_CALC_WAIT) begin
            r_wait <= '0;
        end else begin
            r_wait <= r_wait + 1'b1;
        end
    end

    // butterfly stage index, back to 0 after the last stage
    always_ff @(posedge clk) begin
        if (reset || w_abort) begin
            r_stage <= '0;
        end else if (w_stage_step) begin
            r_stage <= (r_stage == STAGE_LAST) ? '0 : r_stage + 1'b1;
        end
    end

    // next-state decode
    always_comb begin
        w_next       = r_state;
        w_stage_step = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_next = S_FILL;
            end
            S_FILL: begin
                if (w_addr_tc) w_next = S_CALC_PULSE;
            end
            S_CALC_PULSE: begin
                if (CALC_LAT == 0) begin
                    w_stage_step = 1'b1;
                    if (r_stage == STAGE_LAST) w_next = S_READ;
                end else begin
                    w_next = S_CALC_WAIT;
                end
            end
            S_CALC_WAIT: begin
                if (r_wait == WAIT_LAST) begin
                    w_stage_step = 1'b1;
                    w_next = (r_stage == STAGE_LAST) ? S_READ
                                                     : S_CALC_PULSE;
                end
            end
            S_READ: begin
                if (w_addr_tc) w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (w_abort) begin
            w_next       = S_IDLE;
            w_stage_step = 1'b0;
        end
    end

    // Moore outputs decoded from the registered state
    always_comb begin
        busy       = (r_state != S_IDLE);
        done       = (r_state == S_DONE);
        fill_regs  = (r_state == S_FILL) && (w_addr == '0);
        start_calc = (r_state == S_CALC_PULSE);
        we_regs    = (r_state == S_FILL) || (r_state == S_CALC_PULSE);
        sel_in     = (r_state == S_CALC_PULSE) ||
                     (r_state == S_CALC_WAIT) ||
                     (r_state == S_READ);
        out_valid  = (r_state == S_READ);
    end

    assign addr_counter = w_addr;
    assign stage        = r_stage;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl: default build plus a
// CALC_LAT=0 / N_STAGES=1 instance; abort test under FFT_CTRL_ABORT_EN.
module tb_fft_stage_ctrl;

    logic clk;
    logic reset;
    logic start;
    logic start6;
`ifdef FFT_CTRL_ABORT_EN
    logic abort;
    logic abort6;
`endif

    logic       busy, done, fill_regs, start_calc, we_regs;
    logic       sel_in, out_valid;
    logic [3:0] addr_counter;
    logic [1:0] stage;

    logic       busy6, done6, fill6, sc6, we6, sel6, ov6;
    logic [3:0] addr6;
    logic [1:0] stage6;

    int compares;
    int fails;

    fft_stage_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
`ifdef FFT_CTRL_ABORT_EN
        .abort        (abort),
`endif
        .busy         (busy),
        .done         (done),
        .fill_regs    (fill_regs),
        .start_calc   (start_calc),
        .we_regs      (we_regs),
        .addr_counter (addr_counter),
        .stage        (stage),
        .sel_in       (sel_in),
        .out_valid    (out_valid)
    );

    fft_stage_ctrl #(
        .CALC_LAT (0),
        .N_STAGES (1)
    ) dut6 (
        .clk          (clk),
        .reset        (reset),
        .start        (start6),
`ifdef FFT_CTRL_ABORT_EN
        .abort        (abort6),
`endif
        .busy         (busy6),
        .done         (done6),
        .fill_regs    (fill6),
        .start_calc   (sc6),
        .we_regs      (we6),
        .addr_counter (addr6),
        .stage        (stage6),
        .sel_in       (sel6),
        .out_valid    (ov6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] vec();
        return {busy, done, fill_regs, start_calc, we_regs,
                sel_in, out_valid, stage, addr_counter};
    endfunction

    function automatic logic [12:0] vec6();
        return {busy6, done6, fill6, sc6, we6,
                sel6, ov6, stage6, addr6};
    endfunction

    // Expected output bundle at cycle c of a frame (cycle 1 = first FILL).
    function automatic logic [12:0] exp_vec(int c, int nst, int lat);
        logic       b, d, f, s, w, sl, o;
        logic [1:0] st;
        logic [3:0] a;
        int         ce;
        b = 0; d = 0; f = 0; s = 0; w = 0; sl = 0; o = 0;
        st = '0; a = '0;
        ce = 16 + nst * (1 + lat);
        if (c >= 1 && c <= 16) begin
            b = 1; w = 1; f = (c == 1); a = 4'(c - 1);
        end else if (c > 16 && c <= ce) begin
            b = 1; sl = 1;
            st = 2'((c - 17) / (1 + lat));
            s = ((c - 17) % (1 + lat)) == 0;
            w = s;
        end else if (c > ce && c <= ce + 16) begin
            b = 1; sl = 1; o = 1; a = 4'(c - ce - 1);
        end else if (c == ce + 17) begin
            b = 1; d = 1;
        end
        return {b, d, f, s, w, sl, o, st, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame();
        reset = 1'b1;
        start = 1'b0;
        tick();
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] v;
        reset = 1'b1;
        start = 1'b1;
        start6 = 1'b1;
        tick();
        tick();
        v = vec();
        compares++;
        if (v !== 13'h0) begin
            fails++;
            $display("FAIL reset_outputs got %h want %h", v, 13'h0);
        end
        v = vec6();
        compares++;
        if (v !== 13'h0) begin
            fails++;
            $display("FAIL reset_outputs6 got %h want %h", v, 13'h0);
        end
        start = 1'b0;
        start6 = 1'b0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_frame();
        logic [12:0] v, e;
        begin_frame();
        for (int c = 1; c <= 48; c++) begin
            v = vec();
            e = exp_vec(c, 4, 2);
            compares++;
            if (v !== e) begin
                fails++;
                $display("FAIL single_frame c=%0d got %h want %h", c, v, e);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] v, e;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b1;
        tick();
        for (int c = 1; c <= 100; c++) begin
            v = vec();
            e = exp_vec(((c - 1) % 46) + 1, 4, 2);
            compares++;
            if (v !== e) begin
                fails++;
                $display("FAIL back_to_back c=%0d got %h want %h", c, v, e);
            end
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        logic [12:0] v, e;
        begin_frame();
        for (int c = 1; c <= 20; c++) begin
            v = vec();
            e = exp_vec(c, 4, 2);
            compares++;
            if (v !== e) begin
                fails++;
                $display("FAIL reset_mid pre c=%0d got %h want %h", c, v, e);
            end
            if (c < 20) tick();
        end
        reset = 1'b1;
        tick();
        v = vec();
        compares++;
        if (v !== 13'h0) begin
            fails++;
            $display("FAIL reset_mid clear got %h want %h", v, 13'h0);
        end
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 46; c++) begin
            v = vec();
            e = exp_vec(c, 4, 2);
            compares++;
            if (v !== e) begin
                fails++;
                $display("FAIL reset_mid post c=%0d got %h want %h", c, v, e);
            end
            tick();
        end
    endtask

    task automatic test_start_in_read();
        logic [12:0] v, e;
        int n_done;
        n_done = 0;
        begin_frame();
        for (int c = 1; c <= 52; c++) begin
            v = vec();
            e = exp_vec(c, 4, 2);
            if (done === 1'b1) n_done++;
            compares++;
            if (v !== e) begin
                fails++;
                $display("FAIL start_in_read c=%0d got %h want %h", c, v, e);
            end
            start = (c == 30) || (c == 45);
            tick();
        end
        start = 1'b0;
        compares++;
        if (n_done !== 1) begin
            fails++;
            $display("FAIL done_count got %0d want %0d", n_done, 1);
        end
    endtask

`ifdef FFT_CTRL_ABORT_EN
    task automatic test_abort();
        logic [12:0] v, e;
        begin_frame();
        for (int c = 1; c <= 10; c++) begin
            v = vec();
            e = exp_vec(c, 4, 2);
            compares++;
            if (v !== e) begin
                fails++;
                $display("FAIL abort pre c=%0d got %h want %h", c, v, e);
            end
            if (c < 10) tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int k = 0; k < 4; k++) begin
            v = vec();
            compares++;
            if (v !== 13'h0) begin
                fails++;
                $display("FAIL abort idle k=%0d got %h want %h", k, v, 13'h0);
            end
            tick();
        end
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            v = vec();
            e = exp_vec(c, 4, 2);
            compares++;
            if (v !== e) begin
                fails++;
                $display("FAIL abort restart c=%0d got %h want %h", c, v, e);
            end
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask
`endif

    task automatic test_short_config();
        logic [12:0] v, e;
        reset = 1'b1;
        start6 = 1'b0;
        tick();
        reset = 1'b0;
        start6 = 1'b1;
        tick();
        start6 = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            v = vec6();
            e = exp_vec(c, 1, 0);
            compares++;
            if (v !== e) begin
                fails++;
                $display("FAIL short_cfg c=%0d got %h want %h", c, v, e);
            end
            tick();
        end
    endtask

    initial begin
        compares = 0;
        fails = 0;
        reset = 1'b1;
        start = 1'b0;
        start6 = 1'b0;
`ifdef FFT_CTRL_ABORT_EN
        abort = 1'b0;
        abort6 = 1'b0;
`endif
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_reset_mid_frame();
        test_start_in_read();
`ifdef FFT_CTRL_ABORT_EN
        test_abort();
`endif
        test_short_config();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compares, fails);
        $finish;
    end

endmodule
